// File: rtl/tetris_pkg.sv
// Shared constants and scan-FSM state type for the board scan-out path.
package tetris_pkg;

  localparam int unsigned ROWS    = 8;
  localparam int unsigned COLS    = 4;
  localparam int unsigned BOARD_W = ROWS * COLS;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } scan_state_e;

  // Row index width; a single-row board still needs one bit.
  function automatic int unsigned idx_width(input int unsigned rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/board_scanout_if.sv
// Row-beat stream from the scan-out engine to its consumer (valid/ready).
interface board_scanout_if #(
  parameter int unsigned ROWS = tetris_pkg::ROWS,
  parameter int unsigned COLS = tetris_pkg::COLS
);
  import tetris_pkg::*;

  localparam int unsigned IDX_W = idx_width(ROWS);

  logic             row_valid;
  logic             row_ready;
  logic [COLS-1:0]  row_data;
  logic [IDX_W-1:0] row_idx;
  logic             row_full;
  logic             sof;
  logic             eof;
  logic             err_flag;

  modport master (
    output row_valid, row_data, row_idx, row_full, sof, eof, err_flag,
    input  row_ready
  );

  modport slave (
    input  row_valid, row_data, row_idx, row_full, sof, eof, err_flag,
    output row_ready
  );

endinterface

// File: rtl/board_row_sel.sv
// Combinational row picker: returns the COLS cells of row i_idx from a flat board.
module board_row_sel #(
  parameter int unsigned ROWS  = tetris_pkg::ROWS,
  parameter int unsigned COLS  = tetris_pkg::COLS,
  parameter int unsigned IDX_W = tetris_pkg::idx_width(ROWS)
) (
  input  logic [ROWS*COLS-1:0] i_board,
  input  logic [IDX_W-1:0]     i_idx,
  output logic [COLS-1:0]      o_row
);
  import tetris_pkg::*;

  always_comb begin
    o_row = COLS'(i_board >> (COLS * i_idx));
  end

endmodule

// File: rtl/board_scanout.sv
// Snapshots a board on load and streams it out row by row, top row first,
// with a one-deep pending frame buffer and a saturating overwrite counter.
module board_scanout #(
  parameter int unsigned ROWS = tetris_pkg::ROWS,
  parameter int unsigned COLS = tetris_pkg::COLS
) (
  input  logic                 clka,
  input  logic                 restart,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] board_in,
  input  logic                 error_in,
  board_scanout_if.master      row_if,
  output logic                 busy,
  output logic [7:0]           drop_cnt
);
  import tetris_pkg::*;

  localparam int unsigned      IDX_W   = idx_width(ROWS);
  localparam int unsigned      BRD_W   = ROWS * COLS;
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(ROWS - 1);

  scan_state_e      r_state, w_nxt_state;
  logic [IDX_W-1:0] r_idx, w_nxt_idx;
  logic [BRD_W-1:0] r_active, w_nxt_active;
  logic [BRD_W-1:0] r_pend, w_nxt_pend;
  logic             r_err, w_nxt_err;
  logic             r_pend_err, w_nxt_pend_err;
  logic             r_pending, w_nxt_pending;
  logic [7:0]       r_drop, w_nxt_drop;
  logic [COLS-1:0]  r_row_data;
  logic             r_full, r_sof, r_eof, r_err_flag;
  logic             w_xfer, w_final, w_drop_inc, w_nxt_valid;
  logic [COLS-1:0]  w_nxt_row;

  // Row shown next cycle, so the beat fields can be registered.
  board_row_sel #(.ROWS(ROWS), .COLS(COLS), .IDX_W(IDX_W)) u_row_sel (
    .i_board (w_nxt_active),
    .i_idx   (w_nxt_idx),
    .o_row   (w_nxt_row)
  );

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_idx      = r_idx;
    w_nxt_active   = r_active;
    w_nxt_err      = r_err;
    w_nxt_pend     = r_pend;
    w_nxt_pend_err = r_pend_err;
    w_nxt_pending  = r_pending;
    w_nxt_drop     = r_drop;
    w_drop_inc     = 1'b0;
    w_xfer         = (r_state == S_SEND) && row_if.row_ready;
    w_final        = w_xfer && (r_idx == '0);

    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_nxt_state  = S_SEND;
          w_nxt_active = board_in;
          w_nxt_err    = error_in;
          w_nxt_idx    = TOP_IDX;
        end
      end
      S_SEND: begin
        if (w_final) begin
          // A load on the last beat is the newest frame and beats any pending one.
          w_nxt_pending = 1'b0;
          w_nxt_idx     = TOP_IDX;
          if (load) begin
            w_nxt_active = board_in;
            w_nxt_err    = error_in;
            w_drop_inc   = r_pending;
          end else if (r_pending) begin
            w_nxt_active = r_pend;
            w_nxt_err    = r_pend_err;
          end else begin
            w_nxt_state = S_IDLE;
            w_nxt_idx   = '0;
          end
        end else begin
          if (w_xfer) begin
            w_nxt_idx = r_idx - 1'b1;
          end
          if (load) begin
            w_nxt_pend     = board_in;
            w_nxt_pend_err = error_in;
            w_nxt_pending  = 1'b1;
            w_drop_inc     = r_pending;
          end
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase

    if (w_drop_inc && (r_drop != 8'hFF)) begin
      w_nxt_drop = r_drop + 8'd1;
    end
    w_nxt_valid = (w_nxt_state == S_SEND);
  end

  always_ff @(posedge clka) begin
    if (restart) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_active   <= '0;
      r_err      <= 1'b0;
      r_pend     <= '0;
      r_pend_err <= 1'b0;
      r_pending  <= 1'b0;
      r_drop     <= '0;
      r_row_data <= '0;
      r_full     <= 1'b0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
      r_err_flag <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_idx      <= w_nxt_idx;
      r_active   <= w_nxt_active;
      r_err      <= w_nxt_err;
      r_pend     <= w_nxt_pend;
      r_pend_err <= w_nxt_pend_err;
      r_pending  <= w_nxt_pending;
      r_drop     <= w_nxt_drop;
      r_row_data <= w_nxt_valid ? w_nxt_row : '0;
      r_full     <= w_nxt_valid && (&w_nxt_row);
      r_sof      <= w_nxt_valid && (w_nxt_idx == TOP_IDX);
      r_eof      <= w_nxt_valid && (w_nxt_idx == '0);
      r_err_flag <= w_nxt_valid && w_nxt_err;
    end
  end

  assign row_if.row_valid = (r_state == S_SEND);
  assign row_if.row_data  = r_row_data;
  assign row_if.row_idx   = r_idx;
  assign row_if.row_full  = r_full;
  assign row_if.sof       = r_sof;
  assign row_if.eof       = r_eof;
  assign row_if.err_flag  = r_err_flag;
  assign busy             = (r_state == S_SEND);
  assign drop_cnt         = r_drop;

endmodule

// File: doc/board_scanout.md
BOARD_SCANOUT -- requirements
Module: board_scanout

Interface
REQ-001 SHALL take parameter ROWS, default 8, the number of board rows.
REQ-002 SHALL take parameter COLS, default 4, the number of cells per row.
REQ-003 SHALL have these ports:
- clka  in  1  clock, rising edge.
- restart  in  1  synchronous, active-high reset.
- load  in  1  one-cycle request to snapshot and send a board.
- board_in  in  ROWS*COLS  board image; row r is bits [COLS*r+COLS-1 : COLS*r]; row ROWS-1 is the top row.
- error_in  in  1  game-over flag, captured with the board.
- row_valid  out  1  a row beat is presented.
- row_ready  in  1  the consumer accepts the beat.
- row_data  out  COLS  cells of the current row.
- row_idx  out  log2(ROWS)  index of the current row.
- row_full  out  1  row_data is all ones.
- sof  out  1  first beat of a frame.
- eof  out  1  last beat of a frame.
- err_flag  out  1  captured error_in for the current frame.
- busy  out  1  a frame is in progress.
- drop_cnt  out  8  count of frames overwritten while pending; saturating.

Function
REQ-004 SHALL implement a 2-state FSM:
- IDLE -> SEND on load.
- SEND -> IDLE on the final transfer when no frame is pending.
- SEND -> SEND (new frame) on the final transfer when a frame is pending or load is asserted.
REQ-005 A transfer SHALL occur on a rising edge where row_valid=1 and row_ready=1.
REQ-006 load in IDLE SHALL capture board_in and error_in into the active buffer; row_valid=1 SHALL follow in the next cycle with row_idx=ROWS-1 (latency 1).
REQ-007 Rows SHALL be sent top to bottom: ROWS-1 down to 0, one per transfer, with no bubble while row_ready stays high.
REQ-008 row_data, row_idx, row_full, sof, eof and err_flag SHALL hold stable while row_valid=1 and row_ready=0.
REQ-009 sof SHALL be 1 only when row_idx=ROWS-1; eof SHALL be 1 only when row_idx=0; both SHALL be 0 when row_valid=0.
REQ-010 row_full SHALL equal (row_data == all ones) and be gated by row_valid.
REQ-011 busy SHALL equal the FSM state being SEND.
REQ-012 Buffering while busy:
- load SHALL capture into a one-deep pending buffer and set pending.
- load while pending is set SHALL overwrite the buffer and increment drop_cnt, saturating at 255.
REQ-013 On the final transfer:
- with pending set, the pending buffer SHALL move to the active buffer and pending SHALL clear.
- the next cycle SHALL present row ROWS-1 of the new frame with row_valid=1.
REQ-014 load coinciding with the final transfer SHALL act as the newest frame:
- with pending clear, board_in SHALL go directly to the active buffer.
- with pending set, board_in SHALL win over the buffered frame and drop_cnt SHALL increment.
REQ-015 The active buffer SHALL never change mid-frame.

Reset
REQ-016 restart SHALL be sampled on rising clka only.
REQ-017 restart SHALL force: state IDLE, row_valid=0, sof=eof=row_full=err_flag=0, busy=0, row_idx=0, row_data=0, pending=0, drop_cnt=0, and both buffers to 0.
REQ-018 restart mid-frame SHALL abort the frame with no further beats; load in the same cycle as restart SHALL be ignored.
REQ-019 From the first cycle after restart deasserts, the block SHALL accept load.

Structure
REQ-020 A shared package (tetris_pkg) SHALL hold ROWS, COLS, BOARD_W = ROWS*COLS, and the scan-FSM state enumeration.
REQ-021 Row selection SHALL be a combinational sub-module, board_row_sel (board, index -> COLS-bit row); the FSM, buffers and counter SHALL stay in board_scanout.

Verification
REQ-022 Basic frame:
- Stimulus: load with board_in=32'hF0000001, error_in=0, row_ready held 1.
- Response: 8 consecutive beats with row_data F,0,0,0,0,0,0,1 at row_idx 7..0; row_full=1 only on the first beat; sof on beat 1; eof on beat 8; busy drops the cycle after the 8th transfer.
REQ-023 Backpressure:
- Stimulus: row_ready=0 for 3 cycles during row 5.
- Response: all outputs held constant; a total of 8 beats, each delivered exactly once.
REQ-024 Pending and drop:
- Stimulus: during a frame, load 32'h11111111 then load 32'h22222222.
- Response: drop_cnt=1; the next frame carries row_data=2 on every row and starts the cycle after the eof transfer.
REQ-025 Coincident load:
- Stimulus: load 32'hFFFFFFFF with error_in=1 on the eof transfer, no pending frame.
- Response: the next cycle shows sof=1, row_data=F, row_full=1, err_flag=1.
REQ-026 Reset mid-frame:
- Stimulus: restart at row 3.
- Response: the next cycle shows row_valid=0, busy=0, drop_cnt=0; no further beats until a new load.
REQ-027 Saturation:
- Stimulus: 300 loads during a single stalled frame.
- Response: drop_cnt=255 (299 overwrites, saturated).
